// File: rtl/m_pile_ctrl_pkg.sv
// Shared geometry, state encoding and small helpers for the pile controller and its datapath.
// Field bit (row r, col c) lives at r*COL_COUNT + c; column c's count lives at [c*CNT_W +: CNT_W].
package m_pile_ctrl_pkg;

  localparam int COL_COUNT              = 6;
  localparam int ROW_COUNT              = 4;
  localparam int COL_SIZE               = 3;
  localparam int CNT_W                  = 3;
  localparam int FIELD_SIZE             = COL_COUNT * ROW_COUNT;
  localparam int PILED_COUNT_ARRAY_SIZE = COL_COUNT * CNT_W;

  typedef enum logic [1:0] {
    PC_IDLE    = 2'd0,
    PC_PILE    = 2'd1,
    PC_PUBLISH = 2'd2,
    PC_OVER    = 2'd3
  } pc_state_e;

  function automatic logic [CNT_W-1:0] get_count(
    input logic [PILED_COUNT_ARRAY_SIZE-1:0] counts,
    input int                                col
  );
    return counts[col*CNT_W +: CNT_W];
  endfunction

  function automatic logic all_full(input logic [PILED_COUNT_ARRAY_SIZE-1:0] counts);
    logic full;
    full = 1'b1;
    for (int c = 0; c < COL_COUNT; c++) begin
      if (counts[c*CNT_W +: CNT_W] != CNT_W'(ROW_COUNT)) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/m_auto_drop_timer.sv
// Auto-drop timer: free-running period counter, a single pending flag and a rotating target column.
// A fresh expiry in the same cycle the pending flag is consumed re-arms it; a clear always wins.
module m_auto_drop_timer
  import m_pile_ctrl_pkg::*;
#(
  parameter int AUTO_PERIOD  = 1000,
  parameter int CNT_PERIOD_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_hold,
  input  logic                i_clear,
  input  logic                i_take,
  output logic                o_pend,
  output logic [COL_SIZE-1:0] o_col
);

  logic [CNT_PERIOD_W-1:0] cnt;
  logic                    expire;

  assign expire = !i_hold && (cnt == CNT_PERIOD_W'(AUTO_PERIOD - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_pend <= 1'b0;
      o_col  <= '0;
    end else begin
      if (expire)
        cnt <= '0;
      else if (!i_hold)
        cnt <= cnt + CNT_PERIOD_W'(1);

      if (i_clear)
        o_pend <= 1'b0;
      else if (expire)
        o_pend <= 1'b1;
      else if (i_take)
        o_pend <= 1'b0;

      if (i_clear)
        o_col <= '0;
      else if (i_take)
        o_col <= (o_col == COL_SIZE'(COL_COUNT - 1)) ? '0 : o_col + COL_SIZE'(1);
    end
  end

endmodule

// File: rtl/m_piler.sv
// Combinational pile datapath: drops one piece onto the lowest free row of the selected column.
// o_valid is low when the column is out of range or already full; outputs then mirror the inputs.
module m_piler
  import m_pile_ctrl_pkg::*;
(
  input  logic [FIELD_SIZE-1:0]             i_field,
  input  logic [PILED_COUNT_ARRAY_SIZE-1:0] i_piled_count_array,
  input  logic [COL_SIZE-1:0]               i_col,
  output logic [FIELD_SIZE-1:0]             o_piled_field,
  output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_count_array,
  output logic                              o_valid
);

  always_comb begin
    o_piled_field       = i_field;
    o_piled_count_array = i_piled_count_array;
    o_valid             = 1'b0;
    for (int c = 0; c < COL_COUNT; c++) begin
      if (i_col == COL_SIZE'(c) &&
          get_count(i_piled_count_array, c) < CNT_W'(ROW_COUNT)) begin
        o_valid = 1'b1;
        o_piled_count_array[c*CNT_W +: CNT_W] = get_count(i_piled_count_array, c) + CNT_W'(1);
        for (int r = 0; r < ROW_COUNT; r++) begin
          if (get_count(i_piled_count_array, c) == CNT_W'(r))
            o_piled_field[r*COL_COUNT + c] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/m_pile_ctrl.sv
// Pile sequencer: arbitrates player and auto drops, commits one pile per request through m_piler,
// publishes each new field to the renderer with a req/ack handshake and detects a full field.
module m_pile_ctrl
  import m_pile_ctrl_pkg::*;
#(
  parameter int AUTO_PERIOD  = 1000,
  parameter int CNT_PERIOD_W = 16,
  parameter int TOTAL_W      = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_drop_req,
  input  logic [COL_SIZE-1:0]               i_drop_col,
  output logic                              o_drop_ack,
  output logic                              o_drop_rej,
  input  logic                              i_clear,
  output logic [FIELD_SIZE-1:0]             o_field,
  output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_count_array,
  output logic                              o_frame_req,
  input  logic                              i_frame_ack,
  output logic                              o_game_over,
  output logic [TOTAL_W-1:0]                o_drop_total
);

  pc_state_e                         state;
  logic [COL_SIZE-1:0]               pile_col;
  logic                              pile_player;
  logic [FIELD_SIZE-1:0]             field;
  logic [PILED_COUNT_ARRAY_SIZE-1:0] counts;
  logic [TOTAL_W-1:0]                total;

  logic                              auto_pend;
  logic [COL_SIZE-1:0]               auto_col;
  logic [FIELD_SIZE-1:0]             piled_field;
  logic [PILED_COUNT_ARRAY_SIZE-1:0] piled_counts;
  logic                              piled_valid;
  logic                              pile_ok;
  logic                              clear_now;
  logic                              auto_take;

  // Clear is only honoured when the field is not being piled or published.
  assign clear_now = i_clear && (state == PC_IDLE || state == PC_OVER);
  assign auto_take = (state == PC_IDLE) && !i_clear && !i_drop_req && auto_pend;
  assign pile_ok   = ({1'b0, pile_col} < (COL_SIZE+1)'(COL_COUNT)) && piled_valid;

  m_auto_drop_timer #(
    .AUTO_PERIOD  (AUTO_PERIOD),
    .CNT_PERIOD_W (CNT_PERIOD_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_hold  (state == PC_OVER),
    .i_clear (clear_now),
    .i_take  (auto_take),
    .o_pend  (auto_pend),
    .o_col   (auto_col)
  );

  m_piler u_piler (
    .i_field             (field),
    .i_piled_count_array (counts),
    .i_col               (pile_col),
    .o_piled_field       (piled_field),
    .o_piled_count_array (piled_counts),
    .o_valid             (piled_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= PC_IDLE;
      pile_col    <= '0;
      pile_player <= 1'b0;
      field       <= '0;
      counts      <= '0;
      total       <= '0;
    end else begin
      case (state)
        PC_IDLE: begin
          if (i_clear) begin
            field  <= '0;
            counts <= '0;
            total  <= '0;
            state  <= PC_PUBLISH;
          end else if (i_drop_req) begin
            pile_col    <= i_drop_col;
            pile_player <= 1'b1;
            state       <= PC_PILE;
          end else if (auto_pend) begin
            pile_col    <= auto_col;
            pile_player <= 1'b0;
            state       <= PC_PILE;
          end
        end
        PC_PILE: begin
          if (pile_ok) begin
            field  <= piled_field;
            counts <= piled_counts;
            total  <= total + TOTAL_W'(1);
            state  <= PC_PUBLISH;
          end else begin
            state <= PC_IDLE;
          end
        end
        PC_PUBLISH: begin
          if (i_frame_ack) state <= all_full(counts) ? PC_OVER : PC_IDLE;
        end
        PC_OVER: begin
          if (i_clear) begin
            field  <= '0;
            counts <= '0;
            total  <= '0;
            state  <= PC_PUBLISH;
          end
        end
        default: state <= PC_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode straight from the state register.
  assign o_drop_ack          = (state == PC_PILE) && pile_player;
  assign o_drop_rej          = o_drop_ack && !pile_ok;
  assign o_frame_req         = (state == PC_PUBLISH);
  assign o_game_over         = (state == PC_OVER);
  assign o_field             = field;
  assign o_piled_count_array = counts;
  assign o_drop_total        = total;

endmodule

// File: tb/tb_m_pile_ctrl.sv
// Directed bench for m_pile_ctrl: one instance with a slow auto timer for player drops,
// one with AUTO_PERIOD=4 for auto-drop ordering, game over, clear and arbitration.
module tb_m_pile_ctrl;
  import m_pile_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              a_rst_n, a_drop_req, a_clear, a_frame_ack;
  logic [COL_SIZE-1:0]               a_drop_col;
  logic                              a_drop_ack, a_drop_rej, a_frame_req, a_game_over;
  logic [FIELD_SIZE-1:0]             a_field;
  logic [PILED_COUNT_ARRAY_SIZE-1:0] a_counts;
  logic [15:0]                       a_total;

  logic                              b_rst_n, b_drop_req, b_clear, b_frame_ack;
  logic [COL_SIZE-1:0]               b_drop_col;
  logic                              b_drop_ack, b_drop_rej, b_frame_req, b_game_over;
  logic [FIELD_SIZE-1:0]             b_field;
  logic [PILED_COUNT_ARRAY_SIZE-1:0] b_counts;
  logic [15:0]                       b_total;

  int checks = 0;
  int errors = 0;

  m_pile_ctrl #(.AUTO_PERIOD(50000), .CNT_PERIOD_W(16), .TOTAL_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_drop_req(a_drop_req), .i_drop_col(a_drop_col),
    .o_drop_ack(a_drop_ack), .o_drop_rej(a_drop_rej), .i_clear(a_clear), .o_field(a_field),
    .o_piled_count_array(a_counts), .o_frame_req(a_frame_req), .i_frame_ack(a_frame_ack),
    .o_game_over(a_game_over), .o_drop_total(a_total)
  );

  m_pile_ctrl #(.AUTO_PERIOD(4), .CNT_PERIOD_W(16), .TOTAL_W(16)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_drop_req(b_drop_req), .i_drop_col(b_drop_col),
    .o_drop_ack(b_drop_ack), .o_drop_rej(b_drop_rej), .i_clear(b_clear), .o_field(b_field),
    .o_piled_count_array(b_counts), .o_frame_req(b_frame_req), .i_frame_ack(b_frame_ack),
    .o_game_over(b_game_over), .o_drop_total(b_total)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [COL_SIZE-1:0] col,
                               input logic clear, input logic frame_ack);
    a_drop_req  = req;
    a_drop_col  = col;
    a_clear     = clear;
    a_frame_ack = frame_ack;
  endtask

  // Raises a player request on dut_a and waits (bounded) for its acknowledge.
  task automatic playerDrop(input string tag, input logic [COL_SIZE-1:0] col,
                            input logic exp_rej, output int latency);
    applyStimulus(1'b1, col, 1'b0, a_frame_ack);
    latency = 0;
    while (!a_drop_ack && latency < 40) begin
      @(negedge clk);
      latency++;
    end
    checkOutput({tag, " ack"}, a_drop_ack, 1);
    checkOutput({tag, " rej"}, a_drop_rej, exp_rej);
    a_drop_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int violations;
    int n_drops;
    int changed_col;
    int drop_order [8];
    logic [PILED_COUNT_ARRAY_SIZE-1:0] prev_counts;

    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    b_drop_req = 1'b0; b_drop_col = '0; b_clear = 1'b0; b_frame_ack = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("reset field",     a_field,     0);
    checkOutput("reset counts",    a_counts,    0);
    checkOutput("reset total",     a_total,     0);
    checkOutput("reset frame_req", a_frame_req, 0);
    checkOutput("reset ack",       a_drop_ack,  0);
    checkOutput("reset rej",       a_drop_rej,  0);
    checkOutput("reset game_over", a_game_over, 0);
    a_rst_n = 1'b1;
    @(negedge clk);

    // Player drop to column 2: ack one cycle after sampling, field one cycle later.
    playerDrop("t1", 3'd2, 1'b0, lat);
    checkOutput("t1 latency", lat, 1);
    checkOutput("t1 counts at ack", a_counts, 0);
    @(negedge clk);
    checkOutput("t1 field",     a_field,     24'h000004);
    checkOutput("t1 counts",    a_counts,    18'h00040);
    checkOutput("t1 frame_req", a_frame_req, 1);
    checkOutput("t1 total",     a_total,     1);
    @(negedge clk);
    checkOutput("t1 frame_req one cycle", a_frame_req, 0);

    // Out-of-range column is acked and rejected with no publish.
    playerDrop("t2", 3'd6, 1'b1, lat);
    @(negedge clk);
    checkOutput("t2 frame_req", a_frame_req, 0);
    checkOutput("t2 field",     a_field,     24'h000004);
    checkOutput("t2 total",     a_total,     1);

    // Fill column 0, then one more drop there must be rejected.
    for (int i = 0; i < 4; i++) begin
      playerDrop("t3 fill", 3'd0, 1'b0, lat);
      repeat (2) @(negedge clk);
    end
    checkOutput("t3 field",  a_field,  24'h041045);
    checkOutput("t3 counts", a_counts, 18'h00044);
    checkOutput("t3 total",  a_total,  5);
    playerDrop("t3 full", 3'd0, 1'b1, lat);
    @(negedge clk);
    checkOutput("t3 counts after rej", a_counts,    18'h00044);
    checkOutput("t3 total after rej",  a_total,     5);
    checkOutput("t3 frame_req",        a_frame_req, 0);

    // Renderer stalls 20 cycles; a player request in that window waits.
    a_frame_ack = 1'b0;
    playerDrop("t4a", 3'd1, 1'b0, lat);
    @(negedge clk);
    checkOutput("t4 field",     a_field,     24'h041047);
    checkOutput("t4 frame_req", a_frame_req, 1);
    a_drop_req = 1'b1;
    a_drop_col = 3'd3;
    violations = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_frame_req !== 1'b1 || a_field !== 24'h041047 || a_drop_ack !== 1'b0) violations++;
    end
    checkOutput("t4 hold window", violations, 0);
    a_frame_ack = 1'b1;
    @(negedge clk);
    checkOutput("t4 frame_req released", a_frame_req, 0);
    checkOutput("t4 ack not yet",        a_drop_ack,  0);
    @(negedge clk);
    checkOutput("t4 pending ack", a_drop_ack, 1);
    checkOutput("t4 pending rej", a_drop_rej, 0);
    a_drop_req = 1'b0;
    @(negedge clk);
    checkOutput("t4b field",  a_field,  24'h04104F);
    checkOutput("t4b counts", a_counts, 18'h0024C);
    checkOutput("t4b total",  a_total,  7);

    // Auto drops on dut_b until the field is full.
    b_rst_n = 1'b1;
    prev_counts = '0;
    n_drops = 0;
    changed_col = -1;
    for (int cyc = 0; cyc < 1000 && !b_game_over; cyc++) begin
      @(negedge clk);
      if (b_counts !== prev_counts) begin
        for (int c = 0; c < COL_COUNT; c++)
          if (b_counts[c*CNT_W +: CNT_W] !== prev_counts[c*CNT_W +: CNT_W]) changed_col = c;
        if (n_drops < 8) drop_order[n_drops] = changed_col;
        n_drops++;
        prev_counts = b_counts;
      end
    end
    checkOutput("t5 game_over", b_game_over, 1);
    checkOutput("t5 drop count", n_drops, 24);
    for (int i = 0; i < 7; i++) checkOutput("t5 auto column order", drop_order[i], i % COL_COUNT);
    checkOutput("t5 full field",  b_field,  24'hFFFFFF);
    checkOutput("t5 full counts", b_counts, 18'h24924);
    checkOutput("t5 total",       b_total,  24);

    // Dwell in OVER, then clear; a held timer expires right after the clear.
    repeat (5) @(negedge clk);
    checkOutput("t5 still over", b_game_over, 1);
    b_clear = 1'b1;
    @(negedge clk);
    b_clear = 1'b0;
    checkOutput("t5 clear field",     b_field,     0);
    checkOutput("t5 clear counts",    b_counts,    0);
    checkOutput("t5 clear total",     b_total,     0);
    checkOutput("t5 clear frame_req", b_frame_req, 1);
    checkOutput("t5 clear game_over", b_game_over, 0);
    repeat (2) @(negedge clk);
    checkOutput("t5 no drop yet", b_counts, 0);
    @(negedge clk);
    checkOutput("t5 first drop after clear", b_counts, 18'h00001);

    // Player request coincides with auto pending: player column first, auto column next.
    b_rst_n = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    b_drop_req = 1'b1;
    b_drop_col = 3'd3;
    @(negedge clk);
    checkOutput("t6 player ack", b_drop_ack, 1);
    checkOutput("t6 player rej", b_drop_rej, 0);
    b_drop_req = 1'b0;
    @(negedge clk);
    checkOutput("t6 player first", b_counts, 18'h00200);
    repeat (3) @(negedge clk);
    checkOutput("t6 auto follows", b_counts, 18'h00201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_pile_ctrl.md
Name: m_pile_ctrl

Overview:
- Sequencer for the combinational `m_piler` datapath. Owns the registered field and per-column piled-count array.
- Arbitrates drop requests from the player input and an internal auto-drop timer, and applies one pile per accepted request.
- Hands each new field to the ST7789 renderer with a req/ack handshake, and detects game over.
- Sits between the input/debounce logic and the display renderer.

Parameters:
- AUTO_PERIOD, 1000: cycles between auto-drop requests. Must be >= 2.
- CNT_PERIOD_W, 16: width of the auto-drop cycle counter.
- TOTAL_W, 16: width of the drop counter.
- Field geometry comes from config.vh, not parameters: `COL_COUNT, `ROW_COUNT, `COL_SIZE, `FIELD_SIZE, `PILED_COUNT_ARRAY_SIZE, `CNT_W.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_drop_req  in  1  player drop request; held high until acknowledged.
- i_drop_col  in  `COL_SIZE  player target column; stable while i_drop_req is high.
- o_drop_ack  out  1  one-cycle pulse: player request consumed.
- o_drop_rej  out  1  one-cycle pulse, coincident with o_drop_ack: request rejected (column out of range or full).
- i_clear  in  1  pulse: empty the field.
- o_field  out  `FIELD_SIZE  current field.
- o_piled_count_array  out  `PILED_COUNT_ARRAY_SIZE  current per-column counts.
- o_frame_req  out  1  new field available; held until i_frame_ack.
- i_frame_ack  in  1  renderer has latched o_field.
- o_game_over  out  1  all columns full.
- o_drop_total  out  TOTAL_W  accepted drops since the last clear.

Behaviour:
- Reset (async, i_rst_n=0): field=0, counts=0, state=IDLE, auto column=0, auto counter=0, auto pending=0, total=0. Every output is 0.
- FSM states: IDLE, PILE, PUBLISH, OVER.
- Auto timer:
  - Counts in every state except OVER; the count is held while in OVER.
  - On reaching AUTO_PERIOD-1 it wraps to 0 and sets auto_pend.
  - auto_pend is a single flag: a second expiry while it is set is lost.
- IDLE priority order:
  1. i_clear: field, counts and total go to 0; auto column goes to 0; auto_pend is cleared; next state PUBLISH.
  2. i_drop_req: latch i_drop_col, mark the request as player, next state PILE.
  3. auto_pend: latch the auto column, clear auto_pend, advance the auto column as (c+1) mod `COL_COUNT, next state PILE.
- PILE (one cycle):
  - The latched column drives `m_piler` together with the registered field and counts.
  - If the column is < `COL_COUNT and o_valid=1: commit o_piled_field/o_piled_count_array, increment total (wraps), next state PUBLISH.
  - Otherwise the field is unchanged; next state is IDLE for player and auto requests alike.
  - Player requests only: o_drop_ack pulses in the PILE cycle; o_drop_rej pulses with it on reject.
  - Latency: request sampled at edge N gives ack in cycle N+1 and the committed field visible from cycle N+2.
- PUBLISH:
  - o_frame_req=1 and the field is frozen until i_frame_ack is sampled high.
  - On ack: if every column count == `ROW_COUNT, go to OVER; otherwise go to IDLE.
  - The player request stays pending; i_clear is ignored in this state.
- OVER:
  - o_game_over=1; drops are not serviced.
  - i_clear behaves as in IDLE, and o_game_over drops on the cycle after the clear.
- o_frame_req is registered, driven purely by state.
- i_frame_ack outside PUBLISH is ignored.
- A player request while auto_pend is set wins; the auto drop follows on the next IDLE.
- Reset mid-PUBLISH or mid-PILE discards everything; no ack is issued.

Decomposition:
- config.vh holds the geometry macros (`COL_COUNT, `ROW_COUNT, `CNT_W and the derived sizes) and the state encodings (`PC_IDLE..`PC_OVER).
- One sub-module is natural: m_auto_drop_timer (counter, pending flag, rotating column).
- `m_piler` is instantiated unchanged.

Test Plan:
- Reset, then a player drop to col 2 with i_frame_ack tied high:
  - ack in cycle N+1, rej=0;
  - count[2]=1 and field bit (row0, col2)=1 from N+2;
  - o_frame_req high for one cycle; total=1.
- i_drop_col=`COL_COUNT (out of range) -> ack+rej pulse together, field unchanged, no frame_req, total unchanged.
- Fill col 0 to `ROW_COUNT, then one more drop to col 0 -> ack+rej, counts unchanged.
- Hold i_frame_ack=0 for 20 cycles after a drop:
  - o_frame_req stays 1 and o_field stays stable;
  - a player request in that window is acked only after the ack is given and IDLE is re-entered.
- AUTO_PERIOD=4, no player input:
  - auto drops land in columns 0,1,...,`COL_COUNT-1,0 in that order;
  - the field fills completely -> o_game_over=1 and the timer is held;
  - an i_clear pulse then zeroes field, counts and total, raises frame_req, and deasserts o_game_over.
- Player request and auto expiry in the same cycle -> the player column piles first; the auto column piles on the following IDLE pass.
